// File: rtl/mem_reader.sv
// Burst reader: streams words from a dual-bank RAM read port and emits them as a
// byte stream (bank0 byte first, then bank1) over a valid/ready handshake.
module mem_reader #(
    parameter int unsigned ADDR_BITS  = 10,
    parameter int unsigned WORD_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_BITS-1:0]  base_addr,
    input  logic [ADDR_BITS:0]    length,
    output logic [ADDR_BITS-1:0]  rd_addr,
    input  logic [WORD_WIDTH-1:0] rd_data,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned LEN_W = ADDR_BITS + 1;

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t               state_q, state_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]     rd_left_q, rd_left_d;
    logic [LEN_W-1:0]     wd_left_q, wd_left_d;
    logic                 inflight_q, inflight_d;
    logic [15:0]          buf_q [2];
    logic [15:0]          buf_d [2];
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [1:0]           cnt_q, cnt_d;
    logic                 half_q, half_d;
    logic [7:0]           out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic issue_c;
    logic load_c;
    logic pop_c;
    logic unused_rd_bits;

    // Parity bits [9] and [0] of each RAM word carry no payload.
    assign unused_rd_bits = ^rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            rd_left_q   <= '0;
            wd_left_q   <= '0;
            inflight_q  <= 1'b0;
            buf_q[0]    <= '0;
            buf_q[1]    <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= '0;
            half_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            rd_left_q   <= rd_left_d;
            wd_left_q   <= wd_left_d;
            inflight_q  <= inflight_d;
            buf_q       <= buf_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        rd_left_d   = rd_left_q;
        wd_left_d   = wd_left_q;
        buf_d       = buf_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        half_d      = half_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        issue_c     = 1'b0;

        // Output register refills whenever it is empty or being consumed.
        load_c = (cnt_q != 2'd0) && (!out_valid_q || out_ready);
        pop_c  = load_c && half_q;

        if (inflight_q) begin
            buf_d[wr_ptr_q] = {rd_data[17:10], rd_data[8:1]};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + 2'(inflight_q) - 2'(pop_c);

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
        if (load_c) begin
            out_valid_d = 1'b1;
            out_data_d  = half_q ? buf_q[rd_ptr_q][15:8] : buf_q[rd_ptr_q][7:0];
            out_last_d  = half_q && (wd_left_q == LEN_W'(1));
            half_d      = ~half_q;
            if (half_q) begin
                wd_left_d = wd_left_q - LEN_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    rd_addr_d = base_addr;
                    rd_left_d = length;
                    wd_left_d = length;
                    half_d    = 1'b0;
                    state_d   = (length == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                // Buffered words plus the in-flight read never exceed two.
                issue_c = (rd_left_q != '0) && ((3'(cnt_q) + 3'(inflight_q)) < 3'd2);
                if (issue_c) begin
                    rd_addr_d = rd_addr_q + ADDR_BITS'(1);
                    rd_left_d = rd_left_q - LEN_W'(1);
                end
                if (out_valid_q && out_ready && out_last_q) begin
                    state_d = FINISH;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        inflight_d = issue_c;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == FINISH);
    end

    assign rd_addr   = rd_addr_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mem_reader.sv
// Directed bench for mem_reader: RAM model plus an arithmetic byte-stream model
// checked on every handshake, with burst-level timing checks.
module tb_mem_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = '0;
    logic [10:0] length = '0;
    logic [9:0]  rd_addr;
    logic [17:0] rd_data = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        busy;
    logic        done;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    int burst_base = 0;
    int burst_len = 0;
    int burst_t0 = -1;
    int ready_mode = 0;
    int stall_until = 0;

    int idx = 0;
    int first_valid_cyc = -1;
    int last_hs_cyc = -1;
    int done_cyc = -1;
    int done_cnt = 0;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic prev_last = 1'b0;

    mem_reader #(.ADDR_BITS(10), .WORD_WIDTH(18)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .length(length), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM: bank0[a]=a[7:0], bank1[a]=~a[7:0]; parity bits set so discarding them matters.
    always @(posedge clk) rd_data <= {~rd_addr[7:0], 1'b1, rd_addr[7:0], 1'b1};

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0)        out_ready = 1'b1;
        else if (cyc < stall_until) out_ready = 1'b0;
        else                        out_ready = 1'($urandom_range(0, 1));
    end

    function automatic void check(string name, longint act, longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic logic [7:0] exp_byte(int base, int k);
        int a = (base + k / 2) % 1024;
        logic [7:0] b = 8'(a);
        return (k % 2 == 0) ? b : ~b;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            idx        = 2 * burst_len;
            prev_stall = 1'b0;
        end else begin
            if (cyc == burst_t0) idx = 0;
            if (prev_stall)
                check("hold", {out_valid, out_last, out_data}, {1'b1, prev_last, prev_data});
            if (out_valid && first_valid_cyc < burst_t0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                check("byte_in_burst", longint'(idx < 2 * burst_len), 1);
                if (idx < 2 * burst_len) begin
                    check("byte_data", out_data, exp_byte(burst_base, idx));
                    check("byte_last", out_last, longint'(idx == 2 * burst_len - 1));
                end
                idx++;
                if (out_last) last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic run_burst(input int base, input int len, input int mode, input bit poke);
        int d0;
        bit got_done;
        got_done   = 1'b0;
        d0         = done_cnt;
        ready_mode = mode;
        burst_base = base;
        burst_len  = len;
        @(posedge clk); #1;
        base_addr = 10'(base);
        length    = 11'(len);
        start     = 1'b1;
        @(posedge clk); #1;
        burst_t0    = cyc;
        start       = 1'b0;
        stall_until = cyc + 10;
        check("rd_addr_load", rd_addr, base);
        check("busy_start", busy, 1);
        if (poke) begin
            base_addr = 10'd500;
            length    = 11'd2;
        end
        for (int i = 0; i < 6000; i++) begin
            if (done === 1'b1) begin
                got_done = 1'b1;
                if (poke) start = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (poke) start = (cyc == burst_t0 + 4);
        end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("done_seen", got_done, 1);
        check("done_pulses", done_cnt - d0, 1);
        if (len == 0) check("done_latency", done_cyc - burst_t0, 0);
        else          check("done_after_last", done_cyc - last_hs_cyc, 1);
        if (mode == 0 && len > 0) check("first_latency", first_valid_cyc - burst_t0, 3);
        check("byte_count", idx, 2 * len);
        check("rd_addr_end", rd_addr, (base + len) % 1024);
        check("busy_end", busy, 0);
        check("valid_end", out_valid, 0);
    endtask

    initial begin
        #3;
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check("model_b0", exp_byte(5, 0), 8'h05);
        check("model_b1", exp_byte(5, 1), 8'hFA);
        check("model_b5", exp_byte(5, 5), 8'hF8);
        check("model_wrap_1023", exp_byte(1022, 2), 8'hFF);
        check("model_wrap_0", exp_byte(1022, 4), 8'h00);
        check("model_wrap_0n", exp_byte(1022, 5), 8'hFF);

        run_burst(5, 3, 0, 1'b0);
        run_burst(1022, 4, 0, 1'b0);
        run_burst(7, 3, 1, 1'b0);
        run_burst(9, 0, 0, 1'b0);

        // Reset mid-burst; the following burst must show no stale bytes.
        ready_mode = 0;
        burst_base = 200;
        burst_len  = 8;
        @(posedge clk); #1;
        base_addr = 10'd200;
        length    = 11'd8;
        start     = 1'b1;
        @(posedge clk); #1;
        burst_t0 = cyc;
        start    = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_rd_addr", rd_addr, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_data", out_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        run_burst(0, 1, 0, 1'b0);

        run_burst(40, 5, 0, 1'b1);
        run_burst(77, 20, 1, 1'b0);
        run_burst(300, 1024, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_reader.md
MEM_READER -- requirements
Module: mem_reader

Interface
REQ-001 The module SHALL provide parameter ADDR_BITS, default 10, which sets the read address width and the wrap modulus 2**ADDR_BITS.
REQ-002 The module SHALL provide parameter WORD_WIDTH, default 18, which sets the packed read-word width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: one-cycle request to begin a burst.
REQ-006 The module SHALL have port base_addr, input, ADDR_BITS: first word address of the burst, sampled with start.
REQ-007 The module SHALL have port length, input, ADDR_BITS+1: word count (0..1024), sampled with start.
REQ-008 The module SHALL have port rd_addr, output, ADDR_BITS: registered word address driven to the dual-bank RAM read port.
REQ-009 The module SHALL have port rd_data, input, WORD_WIDTH: RAM word {bank1[7:0],1'b0,bank0[7:0],1'b0}, valid one cycle after rd_addr.
REQ-010 The module SHALL have port out_data, output, 8 bits: byte stream data.
REQ-011 The module SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-012 The module SHALL have port out_ready, input, 1 bit: the consumer accepts a byte when out_valid and out_ready are both high.
REQ-013 The module SHALL have port out_last, output, 1 bit: marks the final byte of the burst.
REQ-014 The module SHALL have port busy, output, 1 bit: high from the start edge until done.
REQ-015 The module SHALL have port done, output, 1 bit: one-cycle pulse at burst completion.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and FINISH.
REQ-017 In IDLE, start=1 SHALL latch base_addr and length, load rd_addr=base_addr and enter RUN; start SHALL be ignored outside IDLE.
REQ-018 In RUN, at most one read SHALL be issued per cycle, and only when the word buffer (2 entries) plus in-flight reads is below 2.
REQ-019 After each issued read, rd_addr SHALL increment modulo 2**ADDR_BITS (1023 -> 0).
REQ-020 rd_data SHALL be captured into the word buffer exactly one cycle after its read issue; bits [9] and [0] SHALL be discarded.
REQ-021 Each word SHALL emit two bytes in order: rd_data[8:1] (bank0) first, then rd_data[17:10] (bank1).
REQ-022 While out_valid=1 and out_ready=0, out_data, out_valid and out_last SHALL hold stable.
REQ-023 With out_ready held high, the first byte SHALL appear 3 cycles after the start edge, and output SHALL sustain 1 byte/cycle thereafter with no bubbles.
REQ-024 out_last SHALL be 1 only on the bank1 byte of word length-1.
REQ-025 The out_last handshake SHALL move the FSM to FINISH; FINISH SHALL pulse done=1 for one cycle, clear busy and return to IDLE.
REQ-026 length=0 SHALL go IDLE -> FINISH, issue no reads and produce no bytes, with done one cycle after start.
REQ-027 length=1024 SHALL read every address exactly once, wrapping from base_addr through 0.
REQ-028 start asserted in the same cycle as done SHALL be ignored; the earliest new start is the cycle after done.

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE; rd_addr=0; out_data=0; out_valid, out_last, busy and done all 0; buffer and in-flight count cleared.
REQ-030 Reset asserted mid-burst SHALL discard all pending data; after release, no stale byte SHALL appear and the block SHALL accept a new start.

Verification
REQ-031 Setup: RAM model preloaded with bank0[a]=a[7:0], bank1[a]=~a[7:0]. Stimulus: start, base=5, len=3, ready=1. Required: bytes 05,FA,06,F9,07,F8; first byte 3 cycles after start; out_last on F8; done one cycle after.
REQ-032 Stimulus: base=1022, len=4. Required: rd_addr sequence 1022,1023,0,1; 8 bytes in order.
REQ-033 Stimulus: len=3 with out_ready toggled randomly, plus a 10-cycle stall. Required: out_data stable during stalls; no drops or duplicates; at most 2 reads outstanding-plus-buffered.
REQ-034 Stimulus: len=0. Required: no out_valid; done pulse 1 cycle after start; busy returns low.
REQ-035 Stimulus: rst_n low for 1 cycle mid-burst, then start base=0, len=1. Required: only bytes 00,FF appear; no stale data.
REQ-036 Stimulus: start pulsed while busy, and again coincident with done. Required: both ignored; burst output unchanged.
